// File: rtl/neural_layer_engine_pkg.sv
// Shared FSM encoding, end-of-program marker and output saturation for the layer engine.
// Pure definitions: no latency, no flow control.
package neural_layer_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    // Sliced down to ADDR_W at the point of use.
    localparam logic [31:0] END_MARK = '1;

    function automatic logic signed [63:0] sat_relu(
        input logic signed [63:0] v,
        input int                 w,
        input logic               relu
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        else
            r = v;
        if (relu && r[63])
            r = '0;
        return r;
    endfunction

endpackage

// File: rtl/neural_layer_engine_mac_lane.sv
// One MAC lane: wrapping signed accumulate, result saturated (and optionally ReLU'd) combinationally.
// Accumulates on the edge where en is high; clear wins over en; no backpressure.
module mac_lane
    import neural_layer_engine_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 2*DATA_W+4,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic        [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;

    assign prod = x * w;

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

    assign result = DATA_W'(sat_relu(64'(acc), DATA_W, RELU_EN != 0));

endmodule

// File: rtl/neural_layer_engine.sv
// Runs a fully-connected layer program from an instruction ROM, ping-ponging neuron buffers.
// Memories have 1-cycle read latency; one input per MAC cycle, one neuron per WRITE cycle; no backpressure.
module neural_layer_engine
    import neural_layer_engine_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int LANES     = 2,
    parameter int ACC_W     = 2*DATA_W+4,
    parameter int BASE_LOW  = 0,
    parameter int BASE_HIGH = 20,
    parameter int RELU_EN   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       instr_addr,
    input  logic [ADDR_W-1:0]       instr_data,
    output logic [ADDR_W-1:0]       weight_addr,
    input  logic [LANES*DATA_W-1:0] weight_data,
    output logic [ADDR_W-1:0]       nrd_addr,
    input  logic [DATA_W-1:0]       nrd_data,
    output logic                    nwr_en,
    output logic [ADDR_W-1:0]       nwr_addr,
    output logic [DATA_W-1:0]       nwr_data,
    output logic [ADDR_W-1:0]       result_base,
    output logic [ADDR_W-1:0]       result_count
);

    localparam logic [ADDR_W-1:0] BL        = ADDR_W'(BASE_LOW);
    localparam logic [ADDR_W-1:0] BH        = ADDR_W'(BASE_HIGH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(LANES-1);
    localparam logic [ADDR_W:0]   LANES_X   = (ADDR_W+1)'(LANES);

    state_t            state;
    logic [ADDR_W-1:0] ip, wptr, nk, nprev, rd_base, wr_base, g_base, j, wl;
    logic              fcnt, dcnt, v1, v2, acc_clr;
    logic [DATA_W-1:0] lane_res [LANES];

    logic              j_last, grp_last, layer_last;
    logic [ADDR_W:0]   w_next;

    assign j_last     = ({1'b0, j} + (ADDR_W+1)'(1)) >= {1'b0, nprev};
    assign w_next     = {1'b0, g_base} + {1'b0, wl} + (ADDR_W+1)'(1);
    assign grp_last   = (wl == LAST_LANE) || (w_next >= {1'b0, nk});
    assign layer_last = ({1'b0, g_base} + LANES_X) >= {1'b0, nk};

    // v2 marks the cycle in which the memory data for an issued input is valid.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .RELU_EN(RELU_EN)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clear  (acc_clr),
            .en     (v2),
            .x      (nrd_data),
            .w      (weight_data[i*DATA_W +: DATA_W]),
            .result (lane_res[i])
        );
    end

    always_comb begin
        nwr_data = '0;
        for (int i = 0; i < LANES; i++)
            if (wl == ADDR_W'(i))
                nwr_data = lane_res[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ip           <= '0;
            wptr         <= '0;
            nk           <= '0;
            nprev        <= '0;
            rd_base      <= '0;
            wr_base      <= '0;
            g_base       <= '0;
            j            <= '0;
            wl           <= '0;
            fcnt         <= 1'b0;
            dcnt         <= 1'b0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            acc_clr      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            nwr_en       <= 1'b0;
            instr_addr   <= '0;
            weight_addr  <= '0;
            nrd_addr     <= '0;
            nwr_addr     <= '0;
            result_base  <= '0;
            result_count <= '0;
        end else begin
            done    <= 1'b0;
            acc_clr <= 1'b0;
            v1      <= 1'b0;
            v2      <= v1;
            case (state)
                IDLE: if (start) begin
                    ip         <= '0;
                    wptr       <= '0;
                    instr_addr <= '0;
                    fcnt       <= 1'b0;
                    busy       <= 1'b1;
                    state      <= FETCH;
                end
                FETCH: begin
                    fcnt <= ~fcnt;
                    if (fcnt) begin
                        if (ip == '0) begin
                            nprev        <= instr_data;
                            result_base  <= BL;
                            result_count <= instr_data;
                            ip           <= ONE;
                            instr_addr   <= ONE;
                        end else if (instr_data == END_MARK[ADDR_W-1:0] || instr_data == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            nk      <= instr_data;
                            rd_base <= ip[0] ? BL : BH;
                            wr_base <= ip[0] ? BH : BL;
                            g_base  <= '0;
                            j       <= '0;
                            acc_clr <= 1'b1;
                            state   <= MAC;
                        end
                    end
                end
                MAC: begin
                    if (j < nprev) begin
                        nrd_addr    <= rd_base + j;
                        weight_addr <= wptr;
                        wptr        <= wptr + ONE;
                        j           <= j + ONE;
                        v1          <= 1'b1;
                    end
                    if (j_last) begin
                        dcnt  <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    dcnt <= 1'b1;
                    if (dcnt) begin
                        wl       <= '0;
                        nwr_en   <= 1'b1;
                        nwr_addr <= wr_base + g_base;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (grp_last) begin
                        nwr_en <= 1'b0;
                        if (layer_last) begin
                            result_base  <= wr_base;
                            result_count <= nk;
                            nprev        <= nk;
                            ip           <= ip + ONE;
                            instr_addr   <= ip + ONE;
                            fcnt         <= 1'b0;
                            state        <= FETCH;
                        end else begin
                            g_base  <= g_base + LANES_X[ADDR_W-1:0];
                            j       <= '0;
                            acc_clr <= 1'b1;
                            state   <= MAC;
                        end
                    end else begin
                        wl       <= wl + ONE;
                        nwr_addr <= wr_base + w_next[ADDR_W-1:0];
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed bench: two engines (ReLU on / off) against behavioural ROM/RAM models.
module tb_neural_layer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start_b;
    logic        busy, done, nwr_en, busy_b, done_b, nwr_en_b;
    logic [7:0]  instr_addr, instr_data, weight_addr, nrd_addr, nrd_data, nwr_addr, nwr_data, result_base, result_count;
    logic [7:0]  instr_addr_b, instr_data_b, weight_addr_b, nrd_addr_b, nrd_data_b, nwr_addr_b, nwr_data_b, result_base_b, result_count_b;
    logic [15:0] weight_data, weight_data_b;

    logic [7:0]  instr_rom [256];
    logic [15:0] wrom [256];
    logic [7:0]  nram_a [256];
    logic [7:0]  nram_b [256];
    logic        poke_we, poke_sel;
    logic [7:0]  poke_addr, poke_dat;
    logic [7:0]  wa_a[$], wd_a[$], wa_b[$], wd_b[$];
    int          wmax = -1;
    int          checks = 0;
    int          failures = 0;

    neural_layer_engine dut_a (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .nrd_addr(nrd_addr), .nrd_data(nrd_data),
        .nwr_en(nwr_en), .nwr_addr(nwr_addr), .nwr_data(nwr_data),
        .result_base(result_base), .result_count(result_count)
    );

    neural_layer_engine #(.RELU_EN(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .instr_addr(instr_addr_b), .instr_data(instr_data_b),
        .weight_addr(weight_addr_b), .weight_data(weight_data_b),
        .nrd_addr(nrd_addr_b), .nrd_data(nrd_data_b),
        .nwr_en(nwr_en_b), .nwr_addr(nwr_addr_b), .nwr_data(nwr_data_b),
        .result_base(result_base_b), .result_count(result_count_b)
    );

    always @(posedge clk) begin
        instr_data    <= instr_rom[instr_addr];
        weight_data   <= wrom[weight_addr];
        nrd_data      <= nram_a[nrd_addr];
        instr_data_b  <= instr_rom[instr_addr_b];
        weight_data_b <= wrom[weight_addr_b];
        nrd_data_b    <= nram_b[nrd_addr_b];
        if (nwr_en) begin
            nram_a[nwr_addr] <= nwr_data;
            wa_a.push_back(nwr_addr);
            wd_a.push_back(nwr_data);
        end
        if (nwr_en_b) begin
            nram_b[nwr_addr_b] <= nwr_data_b;
            wa_b.push_back(nwr_addr_b);
            wd_b.push_back(nwr_data_b);
        end
        if (poke_we) begin
            if (poke_sel) nram_b[poke_addr] <= poke_dat;
            else          nram_a[poke_addr] <= poke_dat;
        end
        if (start) wmax <= -1;
        else if (busy && int'(weight_addr) > wmax) wmax <= int'(weight_addr);
    end

    task automatic poke(input logic sel, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_we = 1'b1; poke_sel = sel; poke_addr = a; poke_dat = d;
        @(negedge clk);
        poke_we = 1'b0;
    endtask

    task automatic run_a(input int limit, output int cyc, output int pulses);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0; pulses = 0;
        while (done !== 1'b1 && cyc < limit) begin @(negedge clk); cyc++; end
        if (done === 1'b1) pulses = 1;
        repeat (3) begin @(negedge clk); if (done === 1'b1) pulses++; end
    endtask

    task automatic run_b(input int limit, output int cyc, output int pulses);
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        cyc = 0; pulses = 0;
        while (done_b !== 1'b1 && cyc < limit) begin @(negedge clk); cyc++; end
        if (done_b === 1'b1) pulses = 1;
        repeat (3) begin @(negedge clk); if (done_b === 1'b1) pulses++; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, nwr_en, busy_b, done_b, nwr_en_b} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=000000", {busy, done, nwr_en, busy_b, done_b, nwr_en_b});
        end
        checks++;
        if ({instr_addr, weight_addr, nrd_addr, nwr_addr} !== 32'h0) begin
            failures++; $display("FAIL reset_addr got=%h want=00000000", {instr_addr, weight_addr, nrd_addr, nwr_addr});
        end
        checks++;
        if ({result_base, result_count, nwr_data} !== 24'h0) begin
            failures++; $display("FAIL reset_result got=%h want=000000", {result_base, result_count, nwr_data});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_over_start busy=%b want=0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc, pulses, b;
        instr_rom[0] = 8'd2; instr_rom[1] = 8'd2; instr_rom[2] = 8'hFF;
        wrom[0] = {8'd2, 8'd1};
        wrom[1] = {8'd1, 8'd4};
        poke(1'b0, 8'd0, 8'd3);
        poke(1'b0, 8'd1, 8'hFF);
        b = wa_a.size();
        run_a(200, cyc, pulses);
        checks++;
        if (wa_a.size() - b !== 2) begin
            failures++; $display("FAIL basic_nwrites got=%0d want=2", wa_a.size() - b);
        end
        if (wa_a.size() >= b + 2) begin
            checks++;
            if ({wa_a[b], wd_a[b]} !== {8'd20, 8'd0}) begin
                failures++; $display("FAIL basic_w0 got=%0d:%0d want=20:0", wa_a[b], wd_a[b]);
            end
            checks++;
            if ({wa_a[b+1], wd_a[b+1]} !== {8'd21, 8'd5}) begin
                failures++; $display("FAIL basic_w1 got=%0d:%0d want=21:5", wa_a[b+1], wd_a[b+1]);
            end
        end
        checks++;
        if ({result_base, result_count} !== {8'd20, 8'd2}) begin
            failures++; $display("FAIL basic_result got=%0d/%0d want=20/2", result_base, result_count);
        end
        checks++;
        if (pulses !== 1) begin
            failures++; $display("FAIL basic_done_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL basic_busy_after got=%b want=0", busy);
        end
    endtask

    task automatic test_partial_group();
        int cyc, pulses, b;
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        ea = '{8'd20, 8'd21, 8'd22};
        ed = '{8'd7, 8'd4, 8'd6};
        instr_rom[0] = 8'd2; instr_rom[1] = 8'd3; instr_rom[2] = 8'hFF;
        wrom[0] = {8'd2, 8'd1};
        wrom[1] = {8'd1, 8'd3};
        wrom[2] = {8'd5, 8'd2};
        wrom[3] = {8'd7, 8'd2};
        poke(1'b0, 8'd0, 8'd1);
        poke(1'b0, 8'd1, 8'd2);
        b = wa_a.size();
        run_a(200, cyc, pulses);
        checks++;
        if (wa_a.size() - b !== 3) begin
            failures++; $display("FAIL partial_nwrites got=%0d want=3", wa_a.size() - b);
        end
        if (wa_a.size() >= b + 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({wa_a[b+i], wd_a[b+i]} !== {ea[i], ed[i]}) begin
                    failures++; $display("FAIL partial_w%0d got=%0d:%0d want=%0d:%0d", i, wa_a[b+i], wd_a[b+i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (wmax !== 3) begin
            failures++; $display("FAIL partial_wptr max_weight_addr=%0d want=3", wmax);
        end
        checks++;
        if ({result_base, result_count} !== {8'd20, 8'd3}) begin
            failures++; $display("FAIL partial_result got=%0d/%0d want=20/3", result_base, result_count);
        end
    endtask

    task automatic test_three_layers();
        int cyc, pulses, b;
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        ea = '{8'd20, 8'd0, 8'd20};
        ed = '{8'd6, 8'd12, 8'd60};
        instr_rom[0] = 8'd1; instr_rom[1] = 8'd1; instr_rom[2] = 8'd1;
        instr_rom[3] = 8'd1; instr_rom[4] = 8'hFF;
        wrom[0] = {8'd0, 8'd3};
        wrom[1] = {8'd0, 8'd2};
        wrom[2] = {8'd0, 8'd5};
        poke(1'b0, 8'd0, 8'd2);
        b = wa_a.size();
        run_a(300, cyc, pulses);
        checks++;
        if (wa_a.size() - b !== 3) begin
            failures++; $display("FAIL three_nwrites got=%0d want=3", wa_a.size() - b);
        end
        if (wa_a.size() >= b + 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({wa_a[b+i], wd_a[b+i]} !== {ea[i], ed[i]}) begin
                    failures++; $display("FAIL three_w%0d got=%0d:%0d want=%0d:%0d", i, wa_a[b+i], wd_a[b+i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if ({result_base, result_count} !== {8'd20, 8'd1}) begin
            failures++; $display("FAIL three_result got=%0d/%0d want=20/1", result_base, result_count);
        end
        checks++;
        if (pulses !== 1) begin
            failures++; $display("FAIL three_done_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_saturation();
        int cyc, pulses, b;
        instr_rom[0] = 8'd4; instr_rom[1] = 8'd2; instr_rom[2] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            wrom[i] = {8'hFF, 8'h7F};
            poke(1'b0, 8'(i), 8'd127);
            poke(1'b1, 8'(i), 8'd127);
        end
        b = wa_a.size();
        run_a(300, cyc, pulses);
        checks++;
        if (wa_a.size() - b !== 2) begin
            failures++; $display("FAIL sat_relu_nwrites got=%0d want=2", wa_a.size() - b);
        end
        if (wa_a.size() >= b + 2) begin
            checks++;
            if ({wa_a[b], wd_a[b]} !== {8'd20, 8'd127}) begin
                failures++; $display("FAIL sat_pos got=%0d:%0d want=20:127", wa_a[b], wd_a[b]);
            end
            checks++;
            if ({wa_a[b+1], wd_a[b+1]} !== {8'd21, 8'd0}) begin
                failures++; $display("FAIL sat_neg_relu got=%0d:%0d want=21:0", wa_a[b+1], wd_a[b+1]);
            end
        end
        for (int i = 0; i < 4; i++) wrom[i] = {8'h01, 8'h80};
        b = wa_b.size();
        run_b(300, cyc, pulses);
        checks++;
        if (wa_b.size() - b !== 2) begin
            failures++; $display("FAIL sat_norelu_nwrites got=%0d want=2", wa_b.size() - b);
        end
        if (wa_b.size() >= b + 2) begin
            checks++;
            if ({wa_b[b], wd_b[b]} !== {8'd20, 8'h80}) begin
                failures++; $display("FAIL sat_neg got=%0d:%h want=20:80", wa_b[b], wd_b[b]);
            end
            checks++;
            if ({wa_b[b+1], wd_b[b+1]} !== {8'd21, 8'd127}) begin
                failures++; $display("FAIL sat_pos_norelu got=%0d:%0d want=21:127", wa_b[b+1], wd_b[b+1]);
            end
        end
        checks++;
        if ({result_base_b, result_count_b} !== {8'd20, 8'd2}) begin
            failures++; $display("FAIL sat_result_b got=%0d/%0d want=20/2", result_base_b, result_count_b);
        end
    endtask

    task automatic test_short_program();
        int cyc, b;
        instr_rom[0] = 8'd4; instr_rom[1] = 8'hFF;
        b = wa_a.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL short_busy got=%b want=1", busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (done !== 1'b1 || cyc > 4) begin
            failures++; $display("FAIL short_done_latency cycles=%0d done=%b want<=4", cyc, done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wa_a.size() - b !== 0) begin
            failures++; $display("FAIL short_nwrites got=%0d want=0", wa_a.size() - b);
        end
        checks++;
        if ({result_base, result_count, busy} !== {8'd0, 8'd4, 1'b0}) begin
            failures++; $display("FAIL short_result got=%0d/%0d busy=%b want=0/4 busy=0", result_base, result_count, busy);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc, pulses, b;
        instr_rom[0] = 8'd2; instr_rom[1] = 8'd2; instr_rom[2] = 8'hFF;
        wrom[0] = {8'd2, 8'd1};
        wrom[1] = {8'd1, 8'd4};
        poke(1'b0, 8'd0, 8'd3);
        poke(1'b0, 8'd1, 8'hFF);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (nwr_en !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (nwr_en !== 1'b1) begin
            failures++; $display("FAIL midreset_reach_write nwr_en=%b want=1", nwr_en);
        end
        reset = 1'b1;
        @(negedge clk);
        b = wa_a.size();
        checks++;
        if ({nwr_en, busy, done} !== 3'b0) begin
            failures++; $display("FAIL midreset_ctrl got=%b want=000", {nwr_en, busy, done});
        end
        checks++;
        if ({instr_addr, weight_addr, nrd_addr, nwr_addr, nwr_data, result_base, result_count} !== 56'h0) begin
            failures++; $display("FAIL midreset_outputs got=%h want=0", {instr_addr, weight_addr, nrd_addr, nwr_addr, nwr_data, result_base, result_count});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wa_a.size() - b !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_abort writes=%0d busy=%b want=0 busy=0", wa_a.size() - b, busy);
        end
        b = wa_a.size();
        run_a(200, cyc, pulses);
        checks++;
        if (wa_a.size() - b !== 2) begin
            failures++; $display("FAIL rerun_nwrites got=%0d want=2", wa_a.size() - b);
        end
        if (wa_a.size() >= b + 2) begin
            checks++;
            if ({wa_a[b], wd_a[b], wa_a[b+1], wd_a[b+1]} !== {8'd20, 8'd0, 8'd21, 8'd5}) begin
                failures++; $display("FAIL rerun_writes got=%0d:%0d %0d:%0d want=20:0 21:5", wa_a[b], wd_a[b], wa_a[b+1], wd_a[b+1]);
            end
        end
        checks++;
        if ({result_base, result_count} !== {8'd20, 8'd2} || pulses !== 1) begin
            failures++; $display("FAIL rerun_result got=%0d/%0d pulses=%0d want=20/2 pulses=1", result_base, result_count, pulses);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_b = 1'b0;
        poke_we = 1'b0; poke_sel = 1'b0; poke_addr = '0; poke_dat = '0;
        for (int i = 0; i < 256; i++) begin
            instr_rom[i] = '0;
            wrom[i] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_basic();
        test_partial_group();
        test_three_layers();
        test_saturation();
        test_short_program();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neural_layer_engine.md
NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed neuron/weight width.
REQ-002 SHALL have parameter ADDR_W, default 8, width of all memory addresses and layer sizes.
REQ-003 SHALL have parameter LANES, default 2, parallel MAC lanes (1, 2, 4 or 8).
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+4, accumulator width.
REQ-005 SHALL have parameters BASE_LOW, default 0, and BASE_HIGH, default 20, the two ping-pong neuron buffer bases.
REQ-006 SHALL have parameter RELU_EN, default 1, which enables ReLU on written results.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle run request; sampled in IDLE only.
REQ-010 busy  out  1  high from the cycle after accepted start until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 instr_addr  out  ADDR_W  instruction ROM address; instr_data  in  ADDR_W  layer size, 1-cycle read latency.
REQ-013 weight_addr  out  ADDR_W; weight_data  in  LANES*DATA_W  lane i in slice [i*DATA_W +: DATA_W], 1-cycle latency.
REQ-014 nrd_addr  out  ADDR_W; nrd_data  in  DATA_W  neuron RAM read port, 1-cycle latency.
REQ-015 nwr_en  out  1; nwr_addr  out  ADDR_W; nwr_data  out  DATA_W  neuron RAM write port.
REQ-016 result_base  out  ADDR_W; result_count  out  ADDR_W  location and size of the final layer.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, MAC, DRAIN, WRITE, DONE.
REQ-018 IDLE + start SHALL clear the instruction pointer (IP) and weight pointer, then enter FETCH; start outside IDLE is ignored.
REQ-019 FETCH SHALL read instr[IP]; IP=0 gives input count N0, already resident at BASE_LOW.
REQ-020 For IP=k>=1, Nk == all-ones or Nk == 0 SHALL end the program and enter DONE.
REQ-021 Layer k SHALL read from BASE_LOW when k is odd and BASE_HIGH when k is even, and write to the other base.
REQ-022 Neurons SHALL be processed in groups of LANES; group g computes neurons g*LANES .. g*LANES+LANES-1.
REQ-023 MAC SHALL issue one input j and one weight word per cycle for j = 0..N(k-1)-1, incrementing the weight pointer once per issued input.
REQ-024 Each lane SHALL accumulate the signed product of input and lane weight, sign-extended to ACC_W, with wrap-around in ACC_W.
REQ-025 DRAIN SHALL last 2 cycles, absorbing the read latency.
REQ-026 WRITE SHALL emit one neuron per cycle, lane 0 first, at write base + neuron index; lanes whose index >= Nk SHALL NOT be written.
REQ-027 Written value SHALL be the accumulator saturated to signed DATA_W range, then clamped to 0 if negative when RELU_EN=1.
REQ-028 Accumulators SHALL clear at the start of each group.
REQ-029 After the last group, IP SHALL increment and the FSM SHALL return to FETCH.
REQ-030 result_base/result_count SHALL update at each layer end to that layer's write base and Nk; on DONE they hold the final layer's values; if N0 terminates at IP=1, result_base=BASE_LOW and result_count=N0.
REQ-031 DONE SHALL pulse done for one cycle, then return to IDLE with busy low.
REQ-032 nwr_en SHALL never assert in IDLE, FETCH, MAC, DRAIN or DONE.

Reset
REQ-033 reset SHALL force IDLE and clear IP, weight pointer, accumulators, busy, done, nwr_en, all addresses, result_base and result_count to 0, taking priority over start.
REQ-034 reset mid-run SHALL abort with no further writes; a start then restarts from IP=0.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the END_MARK (all-ones) constant and the saturate/ReLU function.
REQ-036 One sub-module, mac_lane (accumulate, saturate, ReLU), SHALL be instantiated LANES times.

Verification
REQ-037 LANES=2, instr={2,2,END}, inputs {3,-1}, weights w(j=0)={1,2}, w(j=1)={4,1} -> writes at BASE_HIGH: 0 (-1 ReLU), 5; result_base=20, result_count=2; one done pulse.
REQ-038 LANES=2, layer size 3 -> only 3 writes occur, lane 1 of group 1 is suppressed, and the weight pointer advances by 2*Nprev.
REQ-039 Saturation: inputs 127, weights 127, Nprev=4 -> written value 127; with RELU_EN=0 and weights -128 -> written value -128.
REQ-040 Three layers -> bases alternate 20, 0, 20; final result_base=20.
REQ-041 reset asserted during WRITE -> nwr_en low the next cycle, all outputs 0; a following start reruns and reproduces the expected results.
REQ-042 instr={4,END} -> done within 4 cycles of start, no writes, result_base=0, result_count=4.
